modport_axil_slave: RTL and testbench

AXI4-Lite slave register file that terminates the `in` modport of the IAXILite interface. It holds NUM_REGS read/write 32-bit control registers and exposes their contents to surrounding logic. It accepts the write address (AW) and write data (W) channels independently and in either order, so it works with masters that present AW first and W only after the AW handshake. It is the generic CPU-visible register block for the monitor's peripherals.

---
 rtl/modport_axil_slave_if.sv | 52 +++++
 rtl/modport_axil_slave.sv | 218 +++++++++++++++++++++
 tb/tb_modport_axil_slave.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/modport_axil_slave_if.sv
// IAXILite: AXI4-Lite bundle. The `in` modport is the slave side and the
// `out` modport is the master side.
interface IAXILite #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport in (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );

    modport out (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );
endinterface

// File: rtl/modport_axil_slave.sv
// AXI4-Lite slave register file. AW and W are captured independently in
// either order. The write commits in the cycle both are available (held or
// handshaking now). Reads are answered one cycle after the AR handshake from
// the register state before any same-cycle commit.
module modport_axil_slave #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    IAXILite.in                            axil,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);
    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int WA_W   = ADDR_WIDTH - 2;      // word address width

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Merge a write into an existing word; an all-zero strobe means full word.
    function automatic logic [DATA_WIDTH-1:0] apply_strobe(
        input logic [DATA_WIDTH-1:0] old_v,
        input logic [DATA_WIDTH-1:0] new_v,
        input logic [STRB_W-1:0]     strb
    );
        logic [STRB_W-1:0]     eff;
        logic [DATA_WIDTH-1:0] res;
        eff = (strb == {STRB_W{1'b0}}) ? {STRB_W{1'b1}} : strb;
        res = old_v;
        for (int i = 0; i < STRB_W; i++) begin
            if (eff[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_v[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Register file and channel state
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q,  w_held_d;
    logic [WA_W-1:0]       awaddr_q,  awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
    logic [STRB_W-1:0]     wstrb_q,   wstrb_d;
    logic                  awready_q, awready_d;
    logic                  wready_q,  wready_d;
    logic                  bvalid_q,  bvalid_d;
    logic [1:0]            bresp_q,   bresp_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q,  rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
    logic [1:0]            rresp_q,   rresp_d;

    // Combinational helpers
    logic                  aw_fire_s, w_fire_s, b_fire_s, ar_fire_s, r_fire_s;
    logic                  commit_s;
    logic [WA_W-1:0]       w_addr_s;
    logic [DATA_WIDTH-1:0] w_data_s;
    logic [STRB_W-1:0]     w_strb_s;
    logic                  w_in_range_s;
    logic [IDX_W-1:0]      w_idx_s;
    logic [WA_W-1:0]       r_addr_s;
    logic                  r_in_range_s;
    logic [IDX_W-1:0]      r_idx_s;

    // Protection bits and byte offsets carry no meaning for this block.
    logic unused_s;
    assign unused_s = ^{axil.awprot, axil.arprot, axil.awaddr[1:0], axil.araddr[1:0]};

    // Write channel: capture AW/W independently, commit when both are present.
    always_comb begin
        aw_fire_s = axil.awvalid && awready_q;
        w_fire_s  = axil.wvalid && wready_q;
        b_fire_s  = bvalid_q && axil.bready;

        w_addr_s = aw_held_q ? awaddr_q : axil.awaddr[ADDR_WIDTH-1:2];
        w_data_s = w_held_q ? wdata_q : axil.wdata;
        w_strb_s = w_held_q ? wstrb_q : axil.wstrb;
        w_in_range_s = (w_addr_s[WA_W-1:IDX_W] == {(WA_W-IDX_W){1'b0}});
        w_idx_s      = w_addr_s[IDX_W-1:0];

        commit_s = (aw_held_q || aw_fire_s) && (w_held_q || w_fire_s) && !bvalid_q;

        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        for (int k = 0; k < NUM_REGS; k++) begin
            regs_d[k] = regs_q[k];
        end

        if (b_fire_s) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b0;
        end else begin
            if (aw_fire_s) begin
                aw_held_d = 1'b1;
                awaddr_d  = axil.awaddr[ADDR_WIDTH-1:2];
            end else begin
                aw_held_d = aw_held_q;
            end
            if (w_fire_s) begin
                w_held_d = 1'b1;
                wdata_d  = axil.wdata;
                wstrb_d  = axil.wstrb;
            end else begin
                w_held_d = w_held_q;
            end
            if (commit_s) begin
                bvalid_d = 1'b1;
                bresp_d  = w_in_range_s ? RESP_OKAY : RESP_SLVERR;
                if (w_in_range_s) begin
                    regs_d[w_idx_s] = apply_strobe(regs_q[w_idx_s], w_data_s, w_strb_s);
                end else begin
                    regs_d[w_idx_s] = regs_q[w_idx_s];
                end
            end else begin
                bvalid_d = bvalid_q;
            end
        end

        awready_d = !aw_held_d && !bvalid_d;
        wready_d  = !w_held_d && !bvalid_d;
    end

    // Read channel: sample the pre-commit register state on the AR handshake.
    always_comb begin
        ar_fire_s    = axil.arvalid && arready_q;
        r_fire_s     = rvalid_q && axil.rready;
        r_addr_s     = axil.araddr[ADDR_WIDTH-1:2];
        r_in_range_s = (r_addr_s[WA_W-1:IDX_W] == {(WA_W-IDX_W){1'b0}});
        r_idx_s      = r_addr_s[IDX_W-1:0];

        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (ar_fire_s) begin
            rvalid_d = 1'b1;
            if (r_in_range_s) begin
                rdata_d = regs_q[r_idx_s];
                rresp_d = RESP_OKAY;
            end else begin
                rdata_d = {DATA_WIDTH{1'b0}};
                rresp_d = RESP_SLVERR;
            end
        end else if (r_fire_s) begin
            rvalid_d = 1'b0;
        end else begin
            rvalid_d = rvalid_q;
        end
        arready_d = !rvalid_d;
    end

    // State registers; readies start low and rise on the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= {DATA_WIDTH{1'b0}};
            end
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= {WA_W{1'b0}};
            wdata_q   <= {DATA_WIDTH{1'b0}};
            wstrb_q   <= {STRB_W{1'b0}};
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= {DATA_WIDTH{1'b0}};
            rresp_q   <= 2'b00;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= regs_d[k];
            end
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // Flatten the register file onto the output bus.
    always_comb begin
        regs_o = {(NUM_REGS*DATA_WIDTH){1'b0}};
        for (int k = 0; k < NUM_REGS; k++) begin
            regs_o[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[k];
        end
    end

    assign axil.awready = awready_q;
    assign axil.wready  = wready_q;
    assign axil.bvalid  = bvalid_q;
    assign axil.bresp   = bresp_q;
    assign axil.arready = arready_q;
    assign axil.rvalid  = rvalid_q;
    assign axil.rdata   = rdata_q;
    assign axil.rresp   = rresp_q;
endmodule

// File: tb/tb_modport_axil_slave.sv
// Randomized self-checking bench for modport_axil_slave with a word-array
// reference model of the register file.
module tb_modport_axil_slave;
    logic         clk;
    logic         rst_n;
    logic [511:0] regs_o;
    int           n_checks;
    int           n_errors;
    logic [31:0]  model_regs [16];

    IAXILite #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

    modport_axil_slave #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .NUM_REGS(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .axil   (bus),
        .regs_o (regs_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 16; k++) model_regs[k] = 32'h0;
    endfunction

    // Byte-enable write on a 16-word map occupying addresses 0x00..0x3F.
    function automatic logic [1:0] model_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] mask;
        if (a >= 16'h0040) return 2'b10;
        mask = 32'h0;
        for (int b = 0; b < 4; b++) if (s[b] || s == 4'h0) mask = mask | (32'hFF << (8*b));
        model_regs[a/4] = (model_regs[a/4] & ~mask) | (d & mask);
        return 2'b00;
    endfunction

    task automatic check_regs(input string tag);
        for (int k = 0; k < 16; k++) check_value(tag, regs_o[k*32 +: 32], model_regs[k]);
    endtask

    task automatic axi_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly);
        bit aw_done, w_done, aw_hs, w_hs;
        int cyc;
        logic [1:0] exp_resp;
        aw_done = 1'b0; w_done = 1'b0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 64) begin
            @(negedge clk);
            bus.awaddr  = addr;
            bus.awprot  = 3'($urandom);
            bus.wdata   = data;
            bus.wstrb   = strb;
            bus.awvalid = !aw_done && (cyc >= aw_dly);
            bus.wvalid  = !w_done && (cyc >= w_dly);
            #1;
            if (aw_done) check_value("awready_while_aw_held", 32'(bus.awready), 32'h0);
            if (w_done)  check_value("wready_while_w_held", 32'(bus.wready), 32'h0);
            check_value("bvalid_before_commit", 32'(bus.bvalid), 32'h0);
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            @(posedge clk);
            if (aw_hs) aw_done = 1'b1;
            if (w_hs)  w_done = 1'b1;
            cyc++;
        end
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        check_value("write_handshake_timeout", {30'h0, aw_done, w_done}, 32'h3);
        exp_resp = model_write(addr, data, strb);
        check_value("bvalid_latency", 32'(bus.bvalid), 32'h1);
        check_value("bresp", 32'(bus.bresp), 32'(exp_resp));
        check_regs("regs_after_write");
        for (int i = 0; i < b_dly; i++) begin
            @(negedge clk);
            check_value("bvalid_held", 32'(bus.bvalid), 32'h1);
            check_value("bresp_stable", 32'(bus.bresp), 32'(exp_resp));
            check_value("awready_during_b", 32'(bus.awready), 32'h0);
            check_value("wready_during_b", 32'(bus.wready), 32'h0);
        end
        bus.bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.bready = 1'b0;
        check_value("bvalid_cleared", 32'(bus.bvalid), 32'h0);
        check_value("awready_after_b", 32'(bus.awready), 32'h1);
        check_value("wready_after_b", 32'(bus.wready), 32'h1);
    endtask

    task automatic axi_read(input logic [15:0] addr, input int r_dly);
        bit done, hs;
        int cyc;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        done = 1'b0; cyc = 0;
        while (!done && cyc < 64) begin
            @(negedge clk);
            bus.araddr  = addr;
            bus.arprot  = 3'($urandom);
            bus.arvalid = 1'b1;
            #1;
            hs = bus.arready;
            @(posedge clk);
            if (hs) done = 1'b1;
            cyc++;
        end
        @(negedge clk);
        bus.arvalid = 1'b0;
        check_value("read_handshake_timeout", 32'(done), 32'h1);
        exp_data = (addr >= 16'h0040) ? 32'h0 : model_regs[addr/4];
        exp_resp = (addr >= 16'h0040) ? 2'b10 : 2'b00;
        check_value("rvalid_latency", 32'(bus.rvalid), 32'h1);
        check_value("rdata", bus.rdata, exp_data);
        check_value("rresp", 32'(bus.rresp), 32'(exp_resp));
        for (int i = 0; i < r_dly; i++) begin
            @(negedge clk);
            check_value("rvalid_held", 32'(bus.rvalid), 32'h1);
            check_value("rdata_stable", bus.rdata, exp_data);
            check_value("arready_during_r", 32'(bus.arready), 32'h0);
        end
        bus.rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rready = 1'b0;
        check_value("rvalid_cleared", 32'(bus.rvalid), 32'h0);
        check_value("arready_after_r", 32'(bus.arready), 32'h1);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
        check_regs("regs_in_reset");
        check_value("awready_in_reset", 32'(bus.awready), 32'h0);
        check_value("arready_in_reset", 32'(bus.arready), 32'h0);
        check_value("bvalid_in_reset", 32'(bus.bvalid), 32'h0);
        check_value("rvalid_in_reset", 32'(bus.rvalid), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check_value("awready_after_reset", 32'(bus.awready), 32'h1);
        check_value("wready_after_reset", 32'(bus.wready), 32'h1);
        check_value("arready_after_reset", 32'(bus.arready), 32'h1);
        check_value("bvalid_after_reset", 32'(bus.bvalid), 32'h0);
        check_value("rvalid_after_reset", 32'(bus.rvalid), 32'h0);
    endtask

    initial begin
        logic [31:0] old_val;
        logic [15:0] a;
        logic [1:0]  sim_resp;
        n_checks = 0;
        n_errors = 0;
        bus.awaddr = 16'h0; bus.awprot = 3'h0; bus.awvalid = 1'b0;
        bus.wdata = 32'h0; bus.wstrb = 4'h0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.araddr = 16'h0; bus.arprot = 3'h0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        rst_n = 1'b0;
        model_reset();

        apply_reset();

        // Write then read, AW ahead of W
        axi_write(16'h0004, 32'hDEADBEEF, 4'hF, 0, 2, 1);
        check_value("reg1_deadbeef", regs_o[63:32], 32'hDEADBEEF);
        axi_read(16'h0004, 0);

        // Byte strobes, including the all-zero strobe
        axi_write(16'h0000, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        axi_write(16'h0000, 32'h12345678, 4'b0101, 0, 0, 0);
        check_value("reg0_strb_0101", regs_o[31:0], 32'hFF34FF78);
        axi_write(16'h0000, 32'hA5A5A5A5, 4'b0000, 1, 0, 0);
        check_value("reg0_strb_0000", regs_o[31:0], 32'hA5A5A5A5);

        // W three cycles ahead of AW, then B backpressure
        axi_write(16'h0010, 32'hCAFEF00D, 4'hF, 3, 0, 4);
        axi_read(16'h0010, 3);

        // Out-of-range accesses
        axi_write(16'h0100, 32'h00000001, 4'hF, 0, 0, 0);
        axi_read(16'h0100, 1);
        check_regs("regs_after_oor");

        // Commit and read of the same register in one cycle return the old value
        old_val = model_regs[3];
        @(negedge clk);
        bus.awaddr = 16'h000C; bus.awvalid = 1'b1;
        bus.wdata = 32'h0BADC0DE; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        bus.araddr = 16'h000C; bus.arvalid = 1'b1;
        #1;
        check_value("sim_ready_all", {29'h0, bus.awready, bus.wready, bus.arready}, 32'h7);
        @(posedge clk);
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        sim_resp = model_write(16'h000C, 32'h0BADC0DE, 4'hF);
        check_value("sim_rdata_old", bus.rdata, old_val);
        check_value("sim_rvalid", 32'(bus.rvalid), 32'h1);
        check_value("sim_bvalid", 32'(bus.bvalid), 32'h1);
        check_value("sim_bresp", 32'(bus.bresp), 32'(sim_resp));
        check_value("sim_reg3_new", regs_o[127:96], 32'h0BADC0DE);
        bus.bready = 1'b1; bus.rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.bready = 1'b0; bus.rready = 1'b0;
        check_value("sim_b_cleared", 32'(bus.bvalid), 32'h0);
        check_value("sim_r_cleared", 32'(bus.rvalid), 32'h0);

        // Randomized traffic against the model
        for (int it = 0; it < 40; it++) begin
            a = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(64, 65535)) : 16'($urandom_range(0, 63));
            axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            a = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(64, 65535)) : 16'($urandom_range(0, 63));
            axi_read(a, $urandom_range(0, 2));
        end

        // Reset after the AW handshake and before W
        @(negedge clk);
        bus.awaddr = 16'h0008; bus.awvalid = 1'b1;
        #1;
        check_value("mid_awready", 32'(bus.awready), 32'h1);
        @(posedge clk);
        @(negedge clk);
        bus.awvalid = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_value("mid_awready_async", 32'(bus.awready), 32'h0);
        check_value("mid_wready_async", 32'(bus.wready), 32'h0);
        check_value("mid_bvalid_async", 32'(bus.bvalid), 32'h0);
        check_regs("mid_regs_cleared");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_value("mid_no_bvalid", 32'(bus.bvalid), 32'h0);
            check_value("mid_awready_back", 32'(bus.awready), 32'h1);
        end
        axi_write(16'h0008, 32'h5A5A1234, 4'hF, 1, 0, 1);
        axi_read(16'h0008, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
